array_access_ctrl: RTL and testbench
====================================

Name: array_access_ctrl

Overview:
Controller and arbiter in front of the 4-word structural register array (array_structural). It shares the array's single write port and single read port between two requesters, A and B, using round-robin arbitration with valid/ready handshakes. It also sequences a zero-fill clear of every word after reset and on request. Read results are registered and returned to the requester that issued the read.

Parameters:
WIDTH, 8, data word width; matches the array's WIDTH.
DEPTH, 4, number of array words; must be a power of 2 and at least 2.
ADDR_W, 2, address width; must equal log2(DEPTH).

Ports:
clk  in  1  rising-edge clock shared with the array
rst_n  in  1  asynchronous active-low reset
clear_start  in  1  single-cycle pulse; requests a zero-fill of all words
clear_busy  out  1  high while the clear sequence runs
a_valid  in  1  requester A has a request
a_ready  out  1  requester A is granted this cycle
a_we  in  1  1 = write, 0 = read
a_addr  in  ADDR_W  word address
a_wdata  in  WIDTH  write data
a_rvalid  out  1  one-cycle pulse; a_rdata holds read data
a_rdata  out  WIDTH  registered read data
b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as A, for requester B
mem_write_en  out  1  to array write_en
mem_write_addr  out  ADDR_W  to array write_addr
mem_write_data  out  WIDTH  to array write_data
mem_read_addr  out  ADDR_W  to array read_addr
mem_read_data  in  WIDTH  from array read_data (combinational mux)

Behaviour:
- States:
  - CLEAR: clear sequence in progress.
  - SERVE: normal arbitration.
  - Reset state is CLEAR, clear count = 0.
- Reset values:
  - Arbitration pointer = A.
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - clear_busy = 1.
- CLEAR state:
  - Each cycle drives mem_write_en = 1, mem_write_addr = count, mem_write_data = 0. count increments.
  - After the edge that writes word DEPTH-1, the state moves to SERVE.
  - The clear therefore takes exactly DEPTH cycles. clear_busy = (state == CLEAR).
  - While in reset, the clear outputs for word 0 are driven; this is harmless.
  - a_ready = b_ready = 0 throughout CLEAR.
  - clear_start is ignored during CLEAR; the count does not restart.
- SERVE state, arbitration:
  - clear_start has priority. If it is high, no grant is issued that cycle; the state goes to CLEAR with count = 0 on the next edge.
  - Otherwise, at most one grant per cycle:
    - Only one requester valid: that requester is granted.
    - Both valid: the requester the pointer selects is granted.
  - After any grant, the pointer moves to the other requester.
  - ready is combinational from valid, state, and pointer. A transfer occurs when valid & ready.
  - Back-to-back grants to one requester are allowed when the other is idle; there are no bubbles.
- Granted write:
  - mem_write_en = 1, with mem_write_addr and mem_write_data taken from the winner, in the same cycle. The array updates at that edge.
- Granted read:
  - mem_read_addr = winner's addr in the same cycle.
  - mem_read_data is captured into the winner's rdata at the edge. The winner's rvalid = 1 for exactly the following cycle.
  - The other requester's rdata holds its value.
- Ordering and idle outputs:
  - A write granted in cycle n is visible to a read granted in cycle n+1 or later.
  - When no write is occurring, mem_write_en = 0, mem_write_addr = 0, mem_write_data = 0.
  - When no read is occurring, mem_read_addr = 0.
- Requester rules:
  - Requesters hold valid and their request fields stable until ready.
  - Dropping valid without a grant is permitted.
- Reset assertion at any time:
  - Immediately forces rvalid = 0 and aborts any transfer in progress.
  - On release, the clear restarts from word 0.

Decomposition:
- Package array_ctrl_pkg holds:
  - the state enum (CLEAR, SERVE);
  - requester index constants REQ_A = 0 and REQ_B = 1;
  - default WIDTH and DEPTH constants.
- One sub-module, rr_arbiter2: a 2-input round-robin arbiter with a registered pointer. Interface: clk, rst_n, req[1:0], enable, grant[1:0].

Test Plan:
1. Release rst_n -> 4 consecutive cycles with mem_write_en = 1, addr 0,1,2,3, data 0x00. clear_busy falls after the 4th edge. a_ready = b_ready = 0 throughout.
2. A writes 0x33 to addr 1, then A reads addr 1 in the next cycle -> a_rvalid pulses one cycle after the read grant with a_rdata = 0x33. b_rvalid stays 0.
3. A and B both hold valid with writes (A: addr i, data i*0x33; B: addr i+2) -> grants alternate A, B, A, B starting with A. Reads of all 4 words return the expected values.
4. Only B valid for 4 consecutive reads of addr 0..3 -> b_ready = 1 on every cycle, and b_rvalid pulses on 4 consecutive cycles.
5. clear_start asserted in the same cycle as a_valid (write 0xAA to addr 2) -> no grant that cycle, followed by a 4-cycle clear. A is then granted, and a later read of addr 2 returns 0xAA while addr 0 returns 0x00.
6. rst_n driven low asynchronously while a read is pending -> a_rvalid = 0 immediately and the pointer returns to A. After release, the full 4-cycle clear repeats before any grant.

Source files
------------

// File: rtl/array_ctrl_pkg.sv
// Shared types and constants for the register-array access controller.
package array_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  localparam int unsigned REQ_A = 0;
  localparam int unsigned REQ_B = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips to the other side after any grant.
// Zero latency; a grant is only issued while enable is high.
module rr_arbiter2
  import array_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (&req) begin
        grant = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant[REQ_A]) begin
      ptr_d = 1'b1;
    end else if (grant[REQ_B]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/array_access_ctrl.sv
// Shares the array's single read and write ports between requesters A and B, and zero-fills the array after reset or on request.
// Read data returns one cycle after the grant; ready is withheld during a clear.
module array_access_ctrl
  import array_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [WIDTH-1:0]  mem_write_data,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [WIDTH-1:0]  mem_read_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        grant;
  logic              arb_en;
  logic              a_rd_fire, b_rd_fire;
  logic              a_rvalid_q, b_rvalid_q;
  logic [WIDTH-1:0]  a_rdata_q, b_rdata_q;

  // clear_start pre-empts arbitration for the cycle it is seen in SERVE
  assign arb_en = (state_q == ST_SERVE) && !clear_start;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({b_valid, a_valid}),
    .enable (arb_en),
    .grant  (grant)
  );

  assign a_ready    = grant[REQ_A];
  assign b_ready    = grant[REQ_B];
  assign a_rd_fire  = grant[REQ_A] && !a_we;
  assign b_rd_fire  = grant[REQ_B] && !b_we;
  assign clear_busy = (state_q == ST_CLEAR);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_write_en   = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;
    mem_read_addr  = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_write_en   = 1'b1;
        mem_write_addr = cnt_q;
        cnt_d          = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_SERVE;
        end
      end
      default: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (grant[REQ_A]) begin
          if (a_we) begin
            mem_write_en   = 1'b1;
            mem_write_addr = a_addr;
            mem_write_data = a_wdata;
          end else begin
            mem_read_addr = a_addr;
          end
        end else if (grant[REQ_B]) begin
          if (b_we) begin
            mem_write_en   = 1'b1;
            mem_write_addr = b_addr;
            mem_write_data = b_wdata;
          end else begin
            mem_read_addr = b_addr;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_rd_fire;
      b_rvalid_q <= b_rd_fire;
      if (a_rd_fire) begin
        a_rdata_q <= mem_read_data;
      end
      if (b_rd_fire) begin
        b_rdata_q <= mem_read_data;
      end
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_array_access_ctrl.sv
// Directed bench for array_access_ctrl with a behavioural 4-word array and a read-data scoreboard.
module tb_array_access_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clear_start;
  logic       clear_busy;
  logic       a_valid, a_ready, a_we, a_rvalid;
  logic [1:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_valid, b_ready, b_we, b_rvalid;
  logic [1:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic       mem_write_en;
  logic [1:0] mem_write_addr, mem_read_addr;
  logic [7:0] mem_write_data, mem_read_data;

  logic [7:0] mem [4];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int total = 0;
  int bad   = 0;

  array_access_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_start    (clear_start),
    .clear_busy     (clear_busy),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_we           (a_we),
    .a_addr         (a_addr),
    .a_wdata        (a_wdata),
    .a_rvalid       (a_rvalid),
    .a_rdata        (a_rdata),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_we           (b_we),
    .b_addr         (b_addr),
    .b_wdata        (b_wdata),
    .b_rvalid       (b_rvalid),
    .b_rdata        (b_rdata),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for array_structural: registered write, combinational read.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
  end
  assign mem_read_data = mem[mem_read_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each returned read word is checked against the queue.
  always @(negedge clk) begin
    if (a_rvalid) begin
      if (exp_a.size() == 0) chk("a_rvalid_unexpected", 1, 0);
      else chk("a_rdata", a_rdata, exp_a.pop_front());
    end
    if (b_rvalid) begin
      if (exp_b.size() == 0) chk("b_rvalid_unexpected", 1, 0);
      else chk("b_rdata", b_rdata, exp_b.pop_front());
    end
  end

  task automatic issue(input bit who, input bit we, input logic [1:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rd);
    bit got;
    got = 1'b0;
    if (!who) begin
      a_we = we; a_addr = addr; a_wdata = wdata; a_valid = 1'b1;
    end else begin
      b_we = we; b_addr = addr; b_wdata = wdata; b_valid = 1'b1;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = who ? b_ready : a_ready;
    end
    chk("grant_seen", {31'd0, got}, 1);
    if (got) begin
      if (we) begin
        chk("wr_en", {31'd0, mem_write_en}, 1);
        chk("wr_addr", {30'd0, mem_write_addr}, {30'd0, addr});
        chk("wr_data", {24'd0, mem_write_data}, {24'd0, wdata});
      end else begin
        chk("rd_addr", {30'd0, mem_read_addr}, {30'd0, addr});
        if (who) exp_b.push_back(exp_rd);
        else exp_a.push_back(exp_rd);
      end
    end
    @(posedge clk); #1;
    if (!who) a_valid = 1'b0;
    else b_valid = 1'b0;
  endtask

  task automatic check_clear(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {31'd0, clear_busy}, 1);
      chk({tag, "_wen"}, {31'd0, mem_write_en}, 1);
      chk({tag, "_waddr"}, {30'd0, mem_write_addr}, i);
      chk({tag, "_wdata"}, {24'd0, mem_write_data}, 0);
      chk({tag, "_rdy"}, {30'd0, a_ready, b_ready}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [4];
    bit         seq  [4];
    int         ai, bi;
    vals = '{8'h00, 8'h33, 8'hC0, 8'hC1};
    seq  = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; clear_start = 1'b0;
    a_valid = 1'b0; a_we = 1'b0; a_addr = 2'd0; a_wdata = 8'h00;
    b_valid = 1'b0; b_we = 1'b0; b_addr = 2'd0; b_wdata = 8'h00;

    // 1: reset state, then a 4-cycle clear with both requesters knocking
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, clear_busy}, 1);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    chk("rst_a_rdata", {24'd0, a_rdata}, 0);
    chk("rst_b_rdata", {24'd0, b_rdata}, 0);
    chk("rst_wen", {31'd0, mem_write_en}, 1);
    chk("rst_waddr", {30'd0, mem_write_addr}, 0);
    rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    check_clear("clr1");
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr1_done", {31'd0, clear_busy}, 0);
    chk("idle_wen", {31'd0, mem_write_en}, 0);
    chk("idle_raddr", {30'd0, mem_read_addr}, 0);

    // 2: write then immediately read back through A; B returns pointer to A
    issue(1'b0, 1'b1, 2'd1, 8'h33, 8'h00);
    issue(1'b0, 1'b0, 2'd1, 8'h00, 8'h33);
    issue(1'b1, 1'b0, 2'd1, 8'h00, 8'h33);

    // 3: contending writers alternate A, B, A, B
    ai = 0; bi = 0;
    a_we = 1'b1; a_addr = 2'd0; a_wdata = 8'h00; a_valid = 1'b1;
    b_we = 1'b1; b_addr = 2'd2; b_wdata = 8'hC0; b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_a_ready", {31'd0, a_ready}, {31'd0, !seq[k]});
      chk("t3_b_ready", {31'd0, b_ready}, {31'd0, seq[k]});
      chk("t3_waddr", {30'd0, mem_write_addr}, seq[k] ? bi + 2 : ai);
      @(posedge clk); #1;
      if (!seq[k]) begin
        ai++;
        if (ai == 2) a_valid = 1'b0;
        else begin a_addr = 2'(ai); a_wdata = 8'(ai * 8'h33); end
      end else begin
        bi++;
        if (bi == 2) b_valid = 1'b0;
        else begin b_addr = 2'(bi + 2); b_wdata = 8'(8'hC0 + bi); end
      end
    end
    for (int k = 0; k < 4; k++) issue(1'b0, 1'b0, 2'(k), 8'h00, vals[k]);

    // 4: B alone streams 4 reads with no bubbles
    b_we = 1'b0; b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_addr = 2'(k);
      @(negedge clk);
      chk("t4_b_ready", {31'd0, b_ready}, 1);
      chk("t4_raddr", {30'd0, mem_read_addr}, k);
      exp_b.push_back(vals[k]);
      if (k > 0) chk("t4_b_rvalid", {31'd0, b_rvalid}, 1);
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    @(negedge clk);
    chk("t4_b_rvalid_last", {31'd0, b_rvalid}, 1);
    @(negedge clk);
    chk("t4_b_rvalid_end", {31'd0, b_rvalid}, 0);

    // 5: clear_start beats a simultaneous A write; the write lands after the clear
    @(posedge clk); #1;
    a_we = 1'b1; a_addr = 2'd2; a_wdata = 8'hAA; a_valid = 1'b1;
    clear_start = 1'b1;
    @(negedge clk);
    chk("t5_no_grant", {30'd0, a_ready, b_ready}, 0);
    chk("t5_no_wen", {31'd0, mem_write_en}, 0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    check_clear("clr2");
    issue(1'b0, 1'b1, 2'd2, 8'hAA, 8'h00);
    issue(1'b0, 1'b0, 2'd2, 8'h00, 8'hAA);
    issue(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    issue(1'b1, 1'b0, 2'd3, 8'h00, 8'h00);

    // 6: reset lands while A's read result is out; pointer (now B) reverts to A
    a_we = 1'b0; a_addr = 2'd2; a_valid = 1'b1;
    @(negedge clk);
    chk("t6_a_ready", {31'd0, a_ready}, 1);
    @(posedge clk); #1;
    chk("t6_rvalid_pre", {31'd0, a_rvalid}, 1);
    chk("t6_rdata_pre", {24'd0, a_rdata}, 8'hAA);
    b_we = 1'b0; b_addr = 2'd0; b_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_rvalid_rst", {31'd0, a_rvalid}, 0);
    chk("t6_rdata_rst", {24'd0, a_rdata}, 0);
    chk("t6_busy_rst", {31'd0, clear_busy}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_clear("clr3");
    @(negedge clk);
    chk("t6_first_a", {30'd0, a_ready, b_ready}, 2'b10);
    exp_a.push_back(8'h00);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk("t6_then_b", {30'd0, a_ready, b_ready}, 2'b01);
    exp_b.push_back(8'h00);
    @(posedge clk); #1;
    b_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
